// File: rtl/tdc_coarse_multi.sv
// tdc_coarse_multi
//   Multi-channel coarse time-to-digital converter. One shared start and N_CH independent stops.
//   Each channel reports the number of whole clk periods from the start edge to its first stop
//   edge. One record per channel per measurement is emitted on a valid/ready stream.
//   Channels without a stop before the counter saturates are reported with m_timeout=1.
//
//   Optional build macro: TDC_INPUT_SYNC_EN
//     Adds a 2-flop synchroniser on start and on each stop ahead of edge detection.
//     Start and stops are delayed equally, so measured times are unchanged.
//
// Ports
//   clk        in   1      system clock, posedge
//   rst        in   1      asynchronous active-high reset
//   start      in   1      rising edge begins a measurement (only while idle)
//   stop       in   N_CH   rising edge captures that channel's time
//   m_valid    out  1      output record valid
//   m_ready    in   1      downstream accept
//   m_ch       out  CH_W   channel index of record
//   m_time     out  CNT_W  coarse time in clk cycles
//   m_timeout  out  1      channel saw no stop; m_time = MAX_CNT
//   busy       out  1      measurement in progress or records still to report
module tdc_coarse_multi #(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned N_CH  = 4,
   localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N_CH-1:0]   stop,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [CH_W-1:0]   m_ch,
   output logic [CNT_W-1:0]  m_time,
   output logic              m_timeout,
   output logic              busy
);

   localparam logic [CNT_W-1:0] MAX_CNT = '1;
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [N_CH-1:0]    hit_q, pending_q, reported_q, timeout_q;
   logic [N_CH-1:0]    hit_d, pending_d, reported_d, timeout_d;
   logic [CNT_W-1:0]   hit_time_q [N_CH];

   logic               start_s, start_q, start_rise;
   logic [N_CH-1:0]    stop_s, stop_q, stop_rise;
   logic [N_CH-1:0]    new_hit, capture;
   logic               at_max, load, sel_any;
   logic [CH_W-1:0]    sel_idx;

   // ---------------------------------------------------------------- input conditioning
`ifdef TDC_INPUT_SYNC_EN
   logic            start_m;
   logic [N_CH-1:0] stop_m;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_m <= 1'b0;
         start_s <= 1'b0;
         stop_m  <= '0;
         stop_s  <= '0;
      end else begin
         start_m <= start;
         start_s <= start_m;
         stop_m  <= stop;
         stop_s  <= stop_m;
      end
   end
`else
   assign start_s = start;
   assign stop_s  = stop;
`endif

   assign start_rise = start_s & ~start_q;
   assign stop_rise  = stop_s & ~stop_q;
   assign at_max     = (state_q == StRun) && (cnt_q == MAX_CNT);
   assign busy       = (state_q != StIdle);
   assign load       = !m_valid || m_ready;

   // Lowest-index pending channel wins the output slot.
   always_comb begin
      sel_any = 1'b0;
      sel_idx = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            sel_any = 1'b1;
            sel_idx = CH_W'(i);
         end
      end
   end

   // ---------------------------------------------------------------- channel flag next-state
   always_comb begin
      new_hit    = '0;
      capture    = '0;
      hit_d      = hit_q;
      pending_d  = pending_q;
      reported_d = reported_q;
      timeout_d  = timeout_q;
      if (load && sel_any) begin
         pending_d[sel_idx]  = 1'b0;
         reported_d[sel_idx] = 1'b1;
      end
      case (state_q)
         StIdle: begin
            if (start_rise) begin
               hit_d      = '0;
               pending_d  = '0;
               reported_d = '0;
               timeout_d  = '0;
            end
         end
         StRun: begin
            new_hit = stop_rise & ~hit_q;
            capture = new_hit;
            // At saturation every channel not yet hit is closed out with time MAX_CNT;
            // those without a stop rise this very cycle are flagged as timeouts.
            if (at_max) begin
               capture   = ~hit_q;
               timeout_d = timeout_q | ~(hit_q | new_hit);
            end
            hit_d     = hit_q | capture;
            pending_d = pending_d | capture;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- FSM, counter, outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         start_q    <= 1'b0;
         stop_q     <= '0;
         hit_q      <= '0;
         pending_q  <= '0;
         reported_q <= '0;
         timeout_q  <= '0;
         for (int i = 0; i < N_CH; i++) hit_time_q[i] <= '0;
         m_valid    <= 1'b0;
         m_ch       <= '0;
         m_time     <= '0;
         m_timeout  <= 1'b0;
      end else begin
         start_q    <= start_s;
         stop_q     <= stop_s;
         hit_q      <= hit_d;
         pending_q  <= pending_d;
         reported_q <= reported_d;
         timeout_q  <= timeout_d;

         for (int i = 0; i < N_CH; i++) begin
            if (capture[i]) hit_time_q[i] <= cnt_q;
         end

         case (state_q)
            StIdle: begin
               if (start_rise) begin
                  state_q <= StRun;
                  cnt_q   <= ONE;
               end
            end
            StRun: begin
               if (at_max || (&hit_d)) state_q <= StDone;
               if (!at_max) cnt_q <= cnt_q + ONE;
            end
            StDone: begin
               if ((&reported_q) && (pending_q == '0)) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase

         // Payload only changes when the slot is empty or being accepted.
         if (load) begin
            m_valid <= sel_any;
            if (sel_any) begin
               m_ch      <= sel_idx;
               m_time    <= hit_time_q[sel_idx];
               m_timeout <= timeout_q[sel_idx];
            end
         end
      end
   end

endmodule

// File: tb/tb_tdc_coarse_multi.sv
// tb_tdc_coarse_multi
//   Directed bench for tdc_coarse_multi. Two instances share clk/rst:
//   u_dut8 (CNT_W=8) for timing/backpressure/reset cases, u_dut4 (CNT_W=4) for timeouts.
//   Accepted records are collected per instance and compared with hand-computed values.
module tb_tdc_coarse_multi;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start8, ready8, v8, to8, busy8;
   logic [3:0] stop8;
   logic [1:0] ch8;
   logic [7:0] t8;
   logic       start4, ready4, v4, to4, busy4;
   logic [3:0] stop4;
   logic [1:0] ch4;
   logic [3:0] t4;

   tdc_coarse_multi #(.CNT_W(8), .N_CH(4)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .stop(stop8), .m_valid(v8), .m_ready(ready8),
      .m_ch(ch8), .m_time(t8), .m_timeout(to8), .busy(busy8)
   );

   tdc_coarse_multi #(.CNT_W(4), .N_CH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .stop(stop4), .m_valid(v4), .m_ready(ready4),
      .m_ch(ch4), .m_time(t4), .m_timeout(to4), .busy(busy4)
   );

   typedef struct packed {
      logic [1:0]  ch;
      logic [7:0]  t;
      logic        to;
      logic [31:0] cyc;
   } rec_t;

   rec_t        q8[$];
   rec_t        q4[$];
   logic [31:0] cyc = '0;
   int          n_vec = 0;
   int          n_err = 0;

   always @(posedge clk) cyc <= cyc + 32'd1;

   // A transfer completes at the next posedge; sample mid-cycle.
   always @(negedge clk) begin
      if (!rst && v8 && ready8) q8.push_back(rec_t'{ch: ch8, t: t8, to: to8, cyc: cyc});
      if (!rst && v4 && ready4) q4.push_back(rec_t'{ch: ch4, t: {4'b0, t4}, to: to4, cyc: cyc});
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_recs(input bit w4, input int n);
      for (int i = 0; i < 400 && (w4 ? q4.size() : q8.size()) < n; i++) tick();
      check(w4 ? "rec_count4" : "rec_count8", w4 ? q4.size() : q8.size(), n);
   endtask

   task automatic rec(input bit w4, input string tag, input int idx, input int ch,
                      input int t, input int to);
      rec_t r;
      if (idx < (w4 ? q4.size() : q8.size())) begin
         r = w4 ? q4[idx] : q8[idx];
         check({tag, "_ch"}, r.ch, ch);
         check({tag, "_time"}, r.t, t);
         check({tag, "_timeout"}, r.to, to);
      end else begin
         check({tag, "_missing"}, w4 ? q4.size() : q8.size(), idx + 1);
      end
   endtask

   // Start detected at edge E0; stop of channel c rises so it is detected at edge E(tt[c]).
   task automatic meas8(input int t0, input int t1, input int t2, input int t3, input int len);
      int tt[4];
      tt = '{t0, t1, t2, t3};
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int k = 1; k <= len; k++) begin
         for (int c = 0; c < 4; c++) if (tt[c] == k) stop8[c] = 1'b1;
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      start8 = 1'b0; stop8 = '0; ready8 = 1'b1;
      start4 = 1'b0; stop4 = '0; ready4 = 1'b1;
      run(3);
      check("rst_valid", v8, 0);
      check("rst_ch", ch8, 0);
      check("rst_time", t8, 0);
      check("rst_timeout", to8, 0);
      check("rst_busy", busy8, 0);
      rst = 1'b0;
      run(2);
      check("idle_valid4", v4, 0);
      check("idle_busy4", busy4, 0);

      // 1: free-flowing output
      q8.delete();
      meas8(5, 10, 10, 20, 25);
      wait_recs(1'b0, 4);
      rec(1'b0, "t1_r0", 0, 0, 5, 0);
      rec(1'b0, "t1_r1", 1, 1, 10, 0);
      rec(1'b0, "t1_r2", 2, 2, 10, 0);
      rec(1'b0, "t1_r3", 3, 3, 20, 0);
      run(2);
      check("t1_busy_end", busy8, 0);
      stop8 = '0;
      run(2);

      // 2: backpressure for 30 cycles, then drain back-to-back
      q8.delete();
      ready8 = 1'b0;
      meas8(5, 10, 10, 20, 30);
      check("t2_hold_valid", v8, 1);
      check("t2_hold_ch", ch8, 0);
      check("t2_hold_time", t8, 5);
      check("t2_busy_held", busy8, 1);
      run(3);
      check("t2_stable_ch", ch8, 0);
      check("t2_stable_time", t8, 5);
      ready8 = 1'b1;
      wait_recs(1'b0, 4);
      rec(1'b0, "t2_r0", 0, 0, 5, 0);
      rec(1'b0, "t2_r1", 1, 1, 10, 0);
      rec(1'b0, "t2_r2", 2, 2, 10, 0);
      rec(1'b0, "t2_r3", 3, 3, 20, 0);
      for (int i = 1; i < 4 && i < q8.size(); i++)
         check("t2_b2b", q8[i].cyc - q8[i-1].cyc, 1);
      run(2);
      check("t2_busy_end", busy8, 0);
      stop8 = '0;
      run(2);

      // 4: start re-pulse and second ch0 stop during RUN are ignored
      q8.delete();
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         if (k == 4) start8 = 1'b1;
         if (k == 5) start8 = 1'b0;
         if (k == 6) stop8[0] = 1'b1;
         if (k == 7) stop8[0] = 1'b0;
         if (k == 8) stop8[0] = 1'b1;
         if (k == 10) stop8[3:1] = 3'b111;
         tick();
      end
      wait_recs(1'b0, 4);
      rec(1'b0, "t4_r0", 0, 0, 6, 0);
      rec(1'b0, "t4_r1", 1, 1, 10, 0);
      rec(1'b0, "t4_r2", 2, 2, 10, 0);
      rec(1'b0, "t4_r3", 3, 3, 10, 0);
      run(3);
      check("t4_busy_end", busy8, 0);
      stop8 = '0;
      run(2);

      // 3: CNT_W=4, only ch1 stops; the rest time out at 15
      q4.delete();
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         if (k == 3) stop4[1] = 1'b1;
         tick();
      end
      wait_recs(1'b1, 4);
      rec(1'b1, "t3_r0", 0, 1, 3, 0);
      rec(1'b1, "t3_r1", 1, 0, 15, 1);
      rec(1'b1, "t3_r2", 2, 2, 15, 1);
      rec(1'b1, "t3_r3", 3, 3, 15, 1);
      run(2);
      check("t3_busy_end", busy4, 0);
      stop4 = '0;
      run(2);

      // 6: ch2 stop rises with start and stays high -> no hit, times out
      q4.delete();
      start4 = 1'b1;
      stop4[2] = 1'b1;
      tick();
      start4 = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         if (k == 1) stop4[0] = 1'b1;
         if (k == 2) stop4[1] = 1'b1;
         if (k == 3) stop4[3] = 1'b1;
         tick();
      end
      wait_recs(1'b1, 4);
      rec(1'b1, "t6_r0", 0, 0, 1, 0);
      rec(1'b1, "t6_r1", 1, 1, 2, 0);
      rec(1'b1, "t6_r2", 2, 3, 3, 0);
      rec(1'b1, "t6_r3", 3, 2, 15, 1);
      run(2);
      stop4 = '0;
      run(2);

      // 5: reset mid-RUN with a record held, then a clean measurement
      q8.delete();
      ready8 = 1'b0;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (k == 3) stop8[0] = 1'b1;
         tick();
      end
      check("t5_pre_valid", v8, 1);
      check("t5_pre_busy", busy8, 1);
      rst = 1'b1;
      #1;
      check("t5_rst_valid", v8, 0);
      check("t5_rst_busy", busy8, 0);
      tick();
      rst = 1'b0;
      stop8 = '0;
      ready8 = 1'b1;
      run(2);
      stop8 = 4'b1111;
      run(5);
      check("t5_idle_recs", q8.size(), 0);
      check("t5_idle_valid", v8, 0);
      check("t5_idle_busy", busy8, 0);
      stop8 = '0;
      tick();
      meas8(2, 4, 6, 7, 10);
      wait_recs(1'b0, 4);
      rec(1'b0, "t5_r0", 0, 0, 2, 0);
      rec(1'b0, "t5_r1", 1, 1, 4, 0);
      rec(1'b0, "t5_r2", 2, 2, 6, 0);
      rec(1'b0, "t5_r3", 3, 3, 7, 0);
      run(2);
      check("t5_busy_end", busy8, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
